shift_left_normalize_pipe: RTL and testbench

Pipelined left-shift normalizer, the inverse direction of the sticky right-shift aligner. It takes a mantissa, its sticky bit and a signed exponent. It shifts the mantissa left until the MSB is 1, reduces the exponent by the shift amount, and passes the sticky bit through unchanged. It sits after the float adder/accumulator datapath and before rounding. Stages use valid/ready handshakes so the block can stall under downstream backpressure.

---
 rtl/shift_left_normalize_pipe_if.sv | 38 +++
 rtl/shift_left_normalize_pipe.sv | 146 ++++++++++++++
 tb/tb_shift_left_normalize_pipe.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_left_normalize_pipe_if.sv
// Stream bundle for the left-shift normalizer: an input beat channel
// (mantissa, sticky, exponent) and an output beat channel (normalized
// mantissa plus zero/underflow flags).
//
// Handshake: a beat moves across a channel on a rising clock edge where
// valid && ready. A producer holds valid and its data stable until that edge.
// The block's inReady never depends on inValid, and outValid/out* never
// depend combinationally on any input.
interface shift_left_normalize_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 6
);
    logic                 inValid;
    logic                 inReady;
    logic [WIDTH-1:0]     inData;
    logic                 inSticky;
    logic [EXP_WIDTH-1:0] inExp;

    logic                 outValid;
    logic                 outReady;
    logic [WIDTH-1:0]     outData;
    logic                 outSticky;
    logic [EXP_WIDTH-1:0] outExp;
    logic                 outZero;
    logic                 outUnderflow;

    // Environment side: produces input beats, consumes output beats.
    modport master (
        output inValid, inData, inSticky, inExp, outReady,
        input  inReady, outValid, outData, outSticky, outExp, outZero, outUnderflow
    );

    // Normalizer side.
    modport slave (
        input  inValid, inData, inSticky, inExp, outReady,
        output inReady, outValid, outData, outSticky, outExp, outZero, outUnderflow
    );
endinterface

// File: rtl/shift_left_normalize_pipe.sv
// Two-stage pipelined left-shift normalizer. Stage 1 captures the beat and
// its leading-zero count; stage 2 shifts the mantissa to MSB=1, lowers the
// exponent by the shift and clamps it at the exponent minimum. The sticky bit
// rides along untouched. Each stage is a one-entry skid-free register that
// loads whenever the stage ahead of it frees up, giving 2 beats of capacity.
module shift_left_normalize_pipe #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 6
) (
    input  logic                        clock,
    input  logic                        resetn,
    shift_left_normalize_pipe_if.slave  bus
);
    localparam int LZW  = $clog2(WIDTH + 1);
    localparam int EXTW = EXP_WIDTH + 1;

    // Most negative exponent, sign-extended and plain.
    localparam logic [EXTW-1:0]      EXP_MIN_EXT = {2'b11, {(EXP_WIDTH-1){1'b0}}};
    localparam logic [EXP_WIDTH-1:0] EXP_MIN     = {1'b1, {(EXP_WIDTH-1){1'b0}}};

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_data_q, s1_data_d;
    logic                 s1_sticky_q, s1_sticky_d;
    logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d;
    logic [LZW-1:0]       s1_lzc_q, s1_lzc_d;

    // Stage 2 state (drives the outputs directly)
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     s2_data_q, s2_data_d;
    logic                 s2_sticky_q, s2_sticky_d;
    logic [EXP_WIDTH-1:0] s2_exp_q, s2_exp_d;
    logic                 s2_zero_q, s2_zero_d;
    logic                 s2_uflow_q, s2_uflow_d;

    logic                 s1_load;
    logic                 s2_load;
    logic [LZW-1:0]       in_lzc;
    logic [EXTW-1:0]      exp_diff;
    logic                 s1_is_zero;

    assign s2_load = !s2_valid_q || bus.outReady;
    assign s1_load = !s1_valid_q || s2_load;

    assign bus.inReady      = !s1_valid_q || !s2_valid_q || bus.outReady;
    assign bus.outValid     = s2_valid_q;
    assign bus.outData      = s2_data_q;
    assign bus.outSticky    = s2_sticky_q;
    assign bus.outExp       = s2_exp_q;
    assign bus.outZero      = s2_zero_q;
    assign bus.outUnderflow = s2_uflow_q;

    // Leading-zero count of the incoming mantissa; the highest set bit wins.
    always_comb begin
        in_lzc = LZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.inData[i]) begin
                in_lzc = LZW'(WIDTH - 1 - i);
            end
        end
    end

    // Stage 1 next state: take a new beat (or a bubble) whenever it can move.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_sticky_d = s1_sticky_q;
        s1_exp_d    = s1_exp_q;
        s1_lzc_d    = s1_lzc_q;
        if (s1_load) begin
            s1_valid_d = bus.inValid;
            if (bus.inValid) begin
                s1_data_d   = bus.inData;
                s1_sticky_d = bus.inSticky;
                s1_exp_d    = bus.inExp;
                s1_lzc_d    = in_lzc;
            end
        end
    end

    // Exponent after the shift, one bit wider so it cannot wrap.
    assign exp_diff   = {s1_exp_q[EXP_WIDTH-1], s1_exp_q} - EXTW'(s1_lzc_q);
    assign s1_is_zero = (s1_lzc_q == LZW'(WIDTH));

    // Stage 2 next state: normalize, clamp the exponent, flag zero/underflow.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_sticky_d = s2_sticky_q;
        s2_exp_d    = s2_exp_q;
        s2_zero_d   = s2_zero_q;
        s2_uflow_d  = s2_uflow_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sticky_d = s1_sticky_q;
                if (s1_is_zero) begin
                    s2_data_d  = '0;
                    s2_exp_d   = '0;
                    s2_zero_d  = 1'b1;
                    s2_uflow_d = 1'b0;
                end else begin
                    // Shift stays full even on underflow; denormals are handled later.
                    s2_data_d = s1_data_q << s1_lzc_q;
                    s2_zero_d = 1'b0;
                    if ($signed(exp_diff) < $signed(EXP_MIN_EXT)) begin
                        s2_exp_d   = EXP_MIN;
                        s2_uflow_d = 1'b1;
                    end else begin
                        s2_exp_d   = exp_diff[EXP_WIDTH-1:0];
                        s2_uflow_d = 1'b0;
                    end
                end
            end
        end
    end

    // Pipeline registers with synchronous active-low clear of every field.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_lzc_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sticky_q <= 1'b0;
            s2_exp_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_uflow_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sticky_q <= s1_sticky_d;
            s1_exp_q    <= s1_exp_d;
            s1_lzc_q    <= s1_lzc_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sticky_q <= s2_sticky_d;
            s2_exp_q    <= s2_exp_d;
            s2_zero_q   <= s2_zero_d;
            s2_uflow_q  <= s2_uflow_d;
        end
    end
endmodule

// File: tb/tb_shift_left_normalize_pipe.sv
// Bench for the left-shift normalizer. Output beats are scored against a
// queue of expected packed results {data, sticky, exp, zero, underflow}.
module tb_shift_left_normalize_pipe;
    localparam int W  = 8;
    localparam int EW = 6;
    localparam int PW = W + 1 + EW + 2;

    logic clock;
    logic resetn;
    int   total;
    int   bad;

    logic [PW-1:0] exp_q[$];

    shift_left_normalize_pipe_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

    shift_left_normalize_pipe #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Directed vectors: inputs and hand-computed results.
    logic [W-1:0]  dir_d  [6] = '{8'h01, 8'h80, 8'h13, 8'h00, 8'h01, 8'h04};
    logic          dir_s  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [EW-1:0] dir_e  [6] = '{6'd0, 6'd5, 6'd31, 6'h3C, 6'h22, 6'h25};
    logic [W-1:0]  dir_od [6] = '{8'h80, 8'h80, 8'h98, 8'h00, 8'h80, 8'h80};
    logic [EW-1:0] dir_oe [6] = '{6'h39, 6'd5, 6'h1C, 6'd0, 6'h20, 6'h20};
    logic          dir_oz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          dir_ou [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    function automatic logic [PW-1:0] pack(input logic [W-1:0] d, input logic s,
                                           input logic [EW-1:0] e, input logic z,
                                           input logic u);
        return {d, s, e, z, u};
    endfunction

    // Reference: shift one bit at a time until the MSB is set.
    function automatic logic [PW-1:0] model(input logic [W-1:0] d, input logic s,
                                            input logic signed [EW-1:0] e);
        logic [W-1:0] m;
        int sh;
        int ex;
        if (d == '0) return pack('0, s, '0, 1'b1, 1'b0);
        m  = d;
        sh = 0;
        while (m[W-1] == 1'b0) begin
            m = m << 1;
            sh++;
        end
        ex = int'(e) - sh;
        if (ex < -(2 ** (EW - 1))) return pack(m, s, {1'b1, {(EW-1){1'b0}}}, 1'b0, 1'b1);
        return pack(m, s, EW'(ex), 1'b0, 1'b0);
    endfunction

    // One clock: score any output transfer at the falling edge, then
    // advance to just after the next rising edge.
    task automatic tick();
        logic [PW-1:0] got;
        logic [PW-1:0] e;
        @(negedge clock);
        if (resetn && bus.outValid && bus.outReady) begin
            got = {bus.outData, bus.outSticky, bus.outExp, bus.outZero, bus.outUnderflow};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_extra_beat got=%h exp=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL scoreboard got=%h exp=%h", got, e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Driver: present a beat until accepted; record its expected result.
    task automatic push(input logic [W-1:0] d, input logic s, input logic [EW-1:0] e,
                        input logic [PW-1:0] exp_v, input bit rnd_ready, output int waited);
        logic acc;
        bus.inValid  = 1'b1;
        bus.inData   = d;
        bus.inSticky = s;
        bus.inExp    = e;
        waited = 0;
        forever begin
            if (rnd_ready) bus.outReady = 1'($urandom_range(0, 1));
            #1;
            acc = bus.inReady;
            tick();
            if (acc) begin
                exp_q.push_back(exp_v);
                break;
            end
            waited++;
            if (waited > 50) begin
                total++;
                bad++;
                $display("FAIL push_timeout got=waited%0d exp=accept", waited);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_leftover got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.inSticky = 1'b0;
        bus.inExp    = '0;
        bus.outReady = 1'b0;
        @(posedge clock);
        #1;
        tick();
        resetn = 1'b1;
        #1;
        total += 7;
        if (bus.outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%b exp=0", bus.outValid); end
        if (bus.outData !== '0) begin bad++; $display("FAIL reset_outData got=%h exp=00", bus.outData); end
        if (bus.outSticky !== 1'b0) begin bad++; $display("FAIL reset_outSticky got=%b exp=0", bus.outSticky); end
        if (bus.outExp !== '0) begin bad++; $display("FAIL reset_outExp got=%h exp=00", bus.outExp); end
        if (bus.outZero !== 1'b0) begin bad++; $display("FAIL reset_outZero got=%b exp=0", bus.outZero); end
        if (bus.outUnderflow !== 1'b0) begin bad++; $display("FAIL reset_outUnderflow got=%b exp=0", bus.outUnderflow); end
        if (bus.inReady !== 1'b1) begin bad++; $display("FAIL reset_inReady got=%b exp=1", bus.inReady); end
    endtask

    task automatic test_latency();
        int w;
        bus.outReady = 1'b1;
        push(8'h01, 1'b1, 6'd0, pack(8'h80, 1'b1, 6'h39, 1'b0, 1'b0), 1'b0, w);
        bus.inValid = 1'b0;
        #1;
        total++;
        if (bus.outValid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", bus.outValid); end
        tick();
        total++;
        if (bus.outValid !== 1'b1) begin bad++; $display("FAIL latency_two_edges got=%b exp=1", bus.outValid); end
        drain();
    endtask

    task automatic test_directed();
        int w;
        bus.outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(dir_d[i], dir_s[i], dir_e[i],
                 pack(dir_od[i], dir_s[i], dir_oe[i], dir_oz[i], dir_ou[i]), 1'b0, w);
            total++;
            if (w != 0) begin bad++; $display("FAIL directed_throughput_%0d got=%0d exp=0", i, w); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        logic [PW-1:0] a_exp;
        logic [PW-1:0] got;
        a_exp = pack(8'h80, 1'b0, 6'd2, 1'b0, 1'b0);
        bus.outReady = 1'b0;
        push(8'h20, 1'b0, 6'd4, a_exp, 1'b0, w);
        total++;
        if (w != 0) begin bad++; $display("FAIL bp_accept_a got=%0d exp=0", w); end
        push(8'h03, 1'b1, 6'd10, model(8'h03, 1'b1, 6'd10), 1'b0, w);
        total++;
        if (w != 0) begin bad++; $display("FAIL bp_accept_b got=%0d exp=0", w); end
        bus.inValid  = 1'b1;
        bus.inData   = 8'h41;
        bus.inSticky = 1'b0;
        bus.inExp    = 6'h3E;
        for (int k = 0; k < 2; k++) begin
            #1;
            got = {bus.outData, bus.outSticky, bus.outExp, bus.outZero, bus.outUnderflow};
            total += 3;
            if (bus.inReady !== 1'b0) begin bad++; $display("FAIL bp_inReady_full got=%b exp=0", bus.inReady); end
            if (bus.outValid !== 1'b1) begin bad++; $display("FAIL bp_outValid_hold got=%b exp=1", bus.outValid); end
            if (got !== a_exp) begin bad++; $display("FAIL bp_hold_a got=%h exp=%h", got, a_exp); end
            tick();
        end
        bus.outReady = 1'b1;
        push(8'h41, 1'b0, 6'h3E, model(8'h41, 1'b0, 6'h3E), 1'b0, w);
        total++;
        if (w != 0) begin bad++; $display("FAIL bp_pop_push_c got=%0d exp=0", w); end
        push(8'h0F, 1'b1, 6'h21, model(8'h0F, 1'b1, 6'h21), 1'b0, w);
        total++;
        if (w != 0) begin bad++; $display("FAIL bp_pop_push_d got=%0d exp=0", w); end
        drain();
    endtask

    task automatic test_reset_mid();
        int w;
        bus.outReady = 1'b0;
        push(8'h11, 1'b1, 6'd7, model(8'h11, 1'b1, 6'd7), 1'b0, w);
        push(8'h22, 1'b0, 6'd9, model(8'h22, 1'b0, 6'd9), 1'b0, w);
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        bus.inData   = 8'h33;
        resetn       = 1'b0;
        tick();
        resetn      = 1'b1;
        bus.inValid = 1'b0;
        exp_q.delete();
        #1;
        total += 4;
        if (bus.outValid !== 1'b0) begin bad++; $display("FAIL rstmid_outValid got=%b exp=0", bus.outValid); end
        if (bus.outData !== '0) begin bad++; $display("FAIL rstmid_outData got=%h exp=00", bus.outData); end
        if (bus.outExp !== '0) begin bad++; $display("FAIL rstmid_outExp got=%h exp=00", bus.outExp); end
        if (bus.inReady !== 1'b1) begin bad++; $display("FAIL rstmid_inReady got=%b exp=1", bus.inReady); end
        push(8'h05, 1'b0, 6'd1, pack(8'hA0, 1'b0, 6'h3C, 1'b0, 1'b0), 1'b0, w);
        drain();
        tick();
        tick();
        total++;
        if (bus.outValid !== 1'b0) begin bad++; $display("FAIL rstmid_ghost_beat got=%b exp=0", bus.outValid); end
    endtask

    task automatic test_soak();
        int w;
        logic [W-1:0]  d;
        logic          s;
        logic [EW-1:0] e;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.inValid  = 1'b0;
                bus.outReady = 1'($urandom_range(0, 1));
                tick();
            end
            d = W'($urandom_range(0, 255)) >> $urandom_range(0, 8);
            s = 1'($urandom_range(0, 1));
            e = EW'($urandom_range(0, 63));
            push(d, s, e, model(d, s, e), 1'b1, w);
        end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
